// File: rtl/neuron_mac.sv
// neuron_mac: bit-serial multiply-accumulate producing bias + sum(x*w) in sign-magnitude fixed point.
// Define NEURON_MAC_SAT_EN to saturate out-of-range results and flag out_ovf; otherwise results wrap.
module neuron_mac #(
    parameter int N = 32,
    parameter int Q = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_w,
    input  logic         in_last,
    input  logic [N-1:0] bias,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_ovf
);
    localparam int M  = N - 1;
    localparam int PW = 2 * M;
    localparam int AW = N + 16;
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {LOAD, MUL, ACC, OUT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] xs_q, prod_q;
    logic [M-1:0]  w_q;
    logic          psign_q, last_q, first_q;
    logic [AW-1:0] acc_q, acc_d, term, bias_tc;
    logic [N-1:0]  out_sum_q, sum_d;
    logic          out_ovf_q, ovf_d;
    logic          in_fire, out_fire, mul_done;
`ifdef NEURON_MAC_SAT_EN
    logic [AW-1:0] acc_abs;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign mul_done = (cnt_q == CW'(M - 1));
    assign out_sum  = out_sum_q;
    assign out_ovf  = out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_valid) state_d = MUL;
            MUL:     if (mul_done) state_d = ACC;
            ACC:     state_d = last_q ? OUT : LOAD;
            OUT:     if (out_ready) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUT);
    end

    // Signed forms of bias and the truncated product; -0 inputs collapse to 0 naturally.
    always_comb begin
        bias_tc = AW'(bias[M-1:0]);
        if (bias[N-1]) bias_tc = -bias_tc;
        term = AW'(prod_q >> Q);
        if (psign_q) term = -term;
        acc_d = acc_q + term;
        ovf_d = 1'b0;
`ifdef NEURON_MAC_SAT_EN
        acc_abs = acc_d[AW-1] ? -acc_d : acc_d;
        if (|acc_abs[AW-1:M]) begin
            sum_d = {acc_d[AW-1], {M{1'b1}}};
            ovf_d = 1'b1;
        end else begin
            sum_d = {acc_d[AW-1], acc_abs[M-1:0]};
        end
`else
        sum_d = {acc_d[AW-1], M'(acc_d[AW-1] ? -acc_d : acc_d)};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            xs_q      <= '0;
            prod_q    <= '0;
            w_q       <= '0;
            psign_q   <= 1'b0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            acc_q     <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (in_fire) begin
                    xs_q    <= PW'(in_x[M-1:0]);
                    w_q     <= in_w[M-1:0];
                    psign_q <= in_x[N-1] ^ in_w[N-1];
                    last_q  <= in_last;
                    prod_q  <= '0;
                    cnt_q   <= '0;
                    first_q <= 1'b0;
                    if (first_q) acc_q <= bias_tc;
                end
                // One multiplier bit per cycle, LSB first; x shifts up to match its weight.
                MUL: begin
                    if (w_q[0]) prod_q <= prod_q + xs_q;
                    xs_q  <= xs_q << 1;
                    w_q   <= w_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (last_q) begin
                        out_sum_q <= sum_d;
                        out_ovf_q <= ovf_d;
                    end
                end
                OUT: if (out_fire) first_q <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed and random vectors scored against an arithmetic model via a result queue.
module tb_neuron_mac;
    localparam int N   = 32;
    localparam int Q   = 24;
    localparam int LAT = 33;
    localparam int TMO = 200;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [N-1:0] in_x = '0, in_w = '0, bias = '0;
    logic         in_ready, out_valid, out_ovf;
    logic [N-1:0] out_sum;
    int           total = 0, bad = 0, cyc = 0, stall_req = 0, stall = 0;

    typedef struct {
        logic [N-1:0] sum;
        logic         ovf;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    neuron_mac #(.N(N), .Q(Q)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .in_last(in_last), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer arithmetic on the decoded values. Returns {ovf, sum}.
    function automatic logic [N:0] model(input logic [N-1:0] xs[$], input logic [N-1:0] ws[$],
                                         input logic [N-1:0] b);
        longint acc, t, mag;
        longint unsigned p;
        logic neg;
        acc = longint'(b[N-2:0]);
        if (b[N-1]) acc = -acc;
        foreach (xs[i]) begin
            p = 64'(xs[i][N-2:0]) * 64'(ws[i][N-2:0]);
            t = longint'(p >> Q);
            if (xs[i][N-1] ^ ws[i][N-1]) t = -t;
            acc += t;
        end
        neg = (acc < 0);
        mag = neg ? -acc : acc;
`ifdef NEURON_MAC_SAT_EN
        if (mag >= (longint'(1) << (N-1))) return {1'b1, neg, {(N-1){1'b1}}};
`endif
        return {1'b0, neg, mag[N-2:0]};
    endfunction

    function automatic logic [N-1:0] rnd(input int mode);
        logic [N-1:0] r = $urandom;
        if ($urandom_range(0, 9) == 0) return {1'b1, {(N-1){1'b0}}};
        if (mode[0]) r[N-2:Q+1] = '0;
        return r;
    endfunction

    // Monitor: latency, hold-under-backpressure, output handshake scoring; also drives out_ready.
    logic         prev_ov = 1'b0, prev_fire = 1'b0;
    logic [N-1:0] prev_sum = '0;
    logic         prev_ovf = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (prev_fire) begin
            chk("in_ready_after_out", in_ready, 1);
            chk("out_valid_after_out", out_valid, 0);
        end
        if (out_valid && !prev_ov) begin
            stall = stall_req;
            chk("pending_result", sb.size() != 0, 1);
            if (sb.size() != 0) chk("latency", cyc, sb[0].cyc);
        end
        if (out_valid) chk("in_ready_in_out", in_ready, 0);
        if (out_valid && prev_ov && !out_ready) begin
            chk("hold_sum", out_sum, prev_sum);
            chk("hold_ovf", out_ovf, prev_ovf);
        end
        prev_sum = out_sum;
        prev_ovf = out_ovf;
        prev_ov  = out_valid;
        if (out_valid && stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = out_valid ? 1'b1 : 1'($urandom_range(0, 1));
        end
        prev_fire = out_valid && out_ready;
        if (prev_fire && sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_sum", out_sum, e.sum);
            chk("out_ovf", out_ovf, e.ovf);
        end
    end

    task automatic send_beat(input logic [N-1:0] x, input logic [N-1:0] w, input logic [N-1:0] b,
                             input logic last, output int hs);
        int n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        bias = b;
        in_last = last;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        hs = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Later beats carry a junk bias to confirm it is only sampled on the first beat.
    task automatic send_vec(input logic [N-1:0] xs[$], input logic [N-1:0] ws[$],
                            input logic [N-1:0] b, input logic [N-1:0] esum, input logic eovf);
        int hs = 0, prev_hs = 0;
        exp_t e;
        for (int i = 0; i < xs.size(); i++) begin
            send_beat(xs[i], ws[i], (i == 0) ? b : N'($urandom), i == xs.size() - 1, hs);
            if (i > 0) chk("beat_spacing", hs - prev_hs, LAT);
            prev_hs = hs;
        end
        e.sum = esum;
        e.ovf = eovf;
        e.cyc = hs + LAT;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [N-1:0] xs[$], ws[$];
        logic [N:0]   r;
        int           hs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        xs = '{32'h01000000}; ws = '{32'h00800000};
        send_vec(xs, ws, 32'h0, 32'h00800000, 1'b0);

        xs = '{32'h83000000, 32'h01000000}; ws = '{32'h01000000, 32'h02000000};
        send_vec(xs, ws, 32'h00400000, 32'h80C00000, 1'b0);

        xs = '{32'h64000000}; ws = '{32'h64000000};
`ifdef NEURON_MAC_SAT_EN
        send_vec(xs, ws, 32'h0, 32'h7FFFFFFF, 1'b1);
`else
        send_vec(xs, ws, 32'h0, 32'h10000000, 1'b0);
`endif

        xs = '{32'h80000000}; ws = '{32'h01000000};
        send_vec(xs, ws, 32'h80000000, 32'h00000000, 1'b0);

        // 2.0 * -1.5 + 0.0625 under 5 cycles of backpressure, then a fresh vector with bias 0.
        drain();
        stall_req = 5;
        xs = '{32'h02000000}; ws = '{32'h81800000};
        send_vec(xs, ws, 32'h00100000, 32'h82F00000, 1'b0);
        drain();
        stall_req = 0;
        xs = '{32'h01000000}; ws = '{32'h01000000};
        send_vec(xs, ws, 32'h0, 32'h01000000, 1'b0);
        drain();

        // Abandon a vector 10 cycles into MUL; nothing may come out for it.
        send_beat(32'h01000000, 32'h01000000, 32'h01000000, 1'b1, hs);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("in_ready_after_rst", in_ready, 1);
        chk("out_valid_after_rst", out_valid, 0);
        xs = '{32'h01000000}; ws = '{32'h01000000};
        send_vec(xs, ws, 32'h0, 32'h01000000, 1'b0);

        for (int v = 0; v < 25; v++) begin
            int nb = $urandom_range(1, 6);
            logic [N-1:0] b;
            xs.delete();
            ws.delete();
            for (int i = 0; i < nb; i++) begin
                xs.push_back(rnd(v));
                ws.push_back(rnd(v));
            end
            b = rnd(v);
            stall_req = $urandom_range(0, 3);
            r = model(xs, ws, b);
            send_vec(xs, ws, b, r[N-1:0], r[N]);
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
